// File: rtl/fir_pkg.sv
// Shared types, default parameters and helper functions for the transposed-form FIR.
package fir_pkg;

  localparam int FIR_TAPS_DEF      = 10;
  localparam int FIR_DIN_W_DEF     = 3;
  localparam int FIR_COEF_W_DEF    = 16;
  localparam int FIR_ACC_W_DEF     = 24;
  localparam int FIR_DOUT_W_DEF    = 16;
  localparam int FIR_OUT_SHIFT_DEF = 0;

  // Result of rounding/saturation: clamped flag plus the value, sign-extended to 64 bits.
  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  // Number of bits needed to index n entries.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Round half up by 'shift' bits, then clamp into a signed dout_w-bit range.
  // The accumulator arrives sign-extended to 64 bits, so the rounding add cannot overflow.
  function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                         input int shift,
                                         input int dout_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           res;
    r = acc;
    if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dout_w - 1));
    res.sat = 1'b0;
    res.val = r;
    if (r > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient storage: shadow bank written at any time,
// copied into the active bank on the first sample strobe after a swap request.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int TAPS   = FIR_TAPS_DEF,
  parameter int COEF_W = FIR_COEF_W_DEF,
  parameter int AW     = clog2(TAPS)
) (
  input  logic                     iClk_12M,
  input  logic                     iRst,
  input  logic                     iEnSample,
  input  logic                     iCoeffWe,
  input  logic [AW-1:0]            iCoeffAddr,
  input  logic [COEF_W-1:0]        iCoeffData,
  input  logic                     iCoeffSwap,
  output logic                     oCoeffPending,
  output logic [TAPS*COEF_W-1:0]   oCoefActive
);

  logic [COEF_W-1:0] shadow [TAPS];
  logic [COEF_W-1:0] active [TAPS];

  // Shadow writes, pending flag and the atomic shadow-to-active copy.
  // The copy reads shadow before this cycle's write lands, so a same-cycle
  // write only reaches the shadow bank.
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      oCoeffPending <= 1'b0;
    end else begin
      if (iCoeffWe && (int'(iCoeffAddr) < TAPS)) shadow[iCoeffAddr] <= iCoeffData;
      if (oCoeffPending && iEnSample) begin
        for (int k = 0; k < TAPS; k++) active[k] <= shadow[k];
        oCoeffPending <= 1'b0;
      end else if (iCoeffSwap) begin
        oCoeffPending <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_flat
    assign oCoefActive[k*COEF_W +: COEF_W] = active[k];
  end

endmodule

// File: rtl/fir_tdf_param.sv
// Parametrised transposed direct-form FIR with cascade port, rounded/saturated
// output, sticky saturation flag and an output-valid strobe.
module fir_tdf_param
  import fir_pkg::*;
#(
  parameter int TAPS      = FIR_TAPS_DEF,
  parameter int DIN_W     = FIR_DIN_W_DEF,
  parameter int COEF_W    = FIR_COEF_W_DEF,
  parameter int ACC_W     = FIR_ACC_W_DEF,
  parameter int DOUT_W    = FIR_DOUT_W_DEF,
  parameter int OUT_SHIFT = FIR_OUT_SHIFT_DEF,
  localparam int AW       = clog2(TAPS)
) (
  input  logic                     iClk_12M,
  input  logic                     iRst,
  input  logic                     iEnSample,
  input  logic signed [DIN_W-1:0]  iFirIn,
  input  logic signed [ACC_W-1:0]  iCascIn,
  input  logic                     iCoeffWe,
  input  logic [AW-1:0]            iCoeffAddr,
  input  logic [COEF_W-1:0]        iCoeffData,
  input  logic                     iCoeffSwap,
  input  logic                     iSatClr,
  output logic                     oCoeffPending,
  output logic signed [ACC_W-1:0]  oCascOut,
  output logic signed [DOUT_W-1:0] oFirOut,
  output logic                     oValid,
  output logic                     oSatFlag
);

  localparam int PROD_W = DIN_W + COEF_W;

  logic [TAPS*COEF_W-1:0]   coef_flat;
  logic signed [PROD_W-1:0] prod_full [TAPS];
  logic signed [ACC_W-1:0]  prod_ext  [TAPS];
  logic signed [ACC_W-1:0]  stage     [TAPS];
  sat_res_t                 sr;

  fir_coef_bank #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W),
    .AW     (AW)
  ) u_coef_bank (
    .iClk_12M      (iClk_12M),
    .iRst          (iRst),
    .iEnSample     (iEnSample),
    .iCoeffWe      (iCoeffWe),
    .iCoeffAddr    (iCoeffAddr),
    .iCoeffData    (iCoeffData),
    .iCoeffSwap    (iCoeffSwap),
    .oCoeffPending (oCoeffPending),
    .oCoefActive   (coef_flat)
  );

  // Full-precision products against the active bank, sign-extended to the accumulator width.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod_full[k] = PROD_W'(iFirIn) * PROD_W'($signed(coef_flat[k*COEF_W +: COEF_W]));
      prod_ext[k]  = ACC_W'(prod_full[k]);
    end
  end

  // Output formatting of the last stage as it stands before the strobe updates it.
  always_comb begin
    sr = sat_round(64'(stage[TAPS-1]), OUT_SHIFT, DOUT_W);
  end

  // Stage chain and output registers; sums wrap at ACC_W bits by design.
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      for (int k = 0; k < TAPS; k++) stage[k] <= '0;
      oCascOut <= '0;
      oFirOut  <= '0;
      oValid   <= 1'b0;
    end else begin
      oValid <= iEnSample;
      if (iEnSample) begin
        stage[0] <= iCascIn + prod_ext[0];
        for (int k = 1; k < TAPS; k++) stage[k] <= stage[k-1] + prod_ext[k];
        oCascOut <= stage[TAPS-1];
        oFirOut  <= DOUT_W'(sr.val);
      end
    end
  end

  // Sticky saturation flag; a clamp in the same cycle as a clear keeps it set.
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      oSatFlag <= 1'b0;
    end else if (iEnSample && sr.sat) begin
      oSatFlag <= 1'b1;
    end else if (iSatClr) begin
      oSatFlag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tdf_param.sv
// Bench for fir_tdf_param: a default instance, a rounding instance (OUT_SHIFT=2)
// and a two-instance cascade, all compared against a convolution model.
module tb_fir_tdf_param;

  localparam int T = 10;
  localparam int N = 1024;

  logic clk = 1'b0;
  always #41 clk = ~clk;

  logic        rst, en, swap, satclr;
  logic [2:0]  x;
  logic [23:0] casc_in;
  logic [2:0]  we_v;
  logic [3:0]  addr;
  logic [15:0] data;

  logic d_pend, d_valid, d_sat; logic [23:0] d_casc; logic [15:0] d_out;
  logic r_pend, r_valid, r_sat; logic [23:0] r_casc; logic [15:0] r_out;
  logic a_pend, a_valid, a_sat; logic [23:0] a_casc; logic [15:0] a_out;
  logic b_pend, b_valid, b_sat; logic [23:0] b_casc; logic [15:0] b_out;

  fir_tdf_param u_dut (
    .iClk_12M(clk), .iRst(rst), .iEnSample(en), .iFirIn(x), .iCascIn(casc_in),
    .iCoeffWe(we_v[0]), .iCoeffAddr(addr), .iCoeffData(data), .iCoeffSwap(swap),
    .iSatClr(satclr), .oCoeffPending(d_pend), .oCascOut(d_casc), .oFirOut(d_out),
    .oValid(d_valid), .oSatFlag(d_sat));

  fir_tdf_param #(.OUT_SHIFT(2)) u_rnd (
    .iClk_12M(clk), .iRst(rst), .iEnSample(en), .iFirIn(x), .iCascIn(casc_in),
    .iCoeffWe(we_v[0]), .iCoeffAddr(addr), .iCoeffData(data), .iCoeffSwap(swap),
    .iSatClr(satclr), .oCoeffPending(r_pend), .oCascOut(r_casc), .oFirOut(r_out),
    .oValid(r_valid), .oSatFlag(r_sat));

  fir_tdf_param u_a (
    .iClk_12M(clk), .iRst(rst), .iEnSample(en), .iFirIn(x), .iCascIn(casc_in),
    .iCoeffWe(we_v[1]), .iCoeffAddr(addr), .iCoeffData(data), .iCoeffSwap(swap),
    .iSatClr(satclr), .oCoeffPending(a_pend), .oCascOut(a_casc), .oFirOut(a_out),
    .oValid(a_valid), .oSatFlag(a_sat));

  fir_tdf_param u_b (
    .iClk_12M(clk), .iRst(rst), .iEnSample(en), .iFirIn(x), .iCascIn(a_casc),
    .iCoeffWe(we_v[2]), .iCoeffAddr(addr), .iCoeffData(data), .iCoeffSwap(swap),
    .iSatClr(satclr), .oCoeffPending(b_pend), .oCascOut(b_casc), .oFirOut(b_out),
    .oValid(b_valid), .oSatFlag(b_sat));

  // Model: per instance (0 = main/rounding, 1 = A, 2 = B) a history of strobes.
  longint shadow_m [3][T];
  longint active_m [3][T];
  bit     pend_m   [3];
  int     n_m      [3];
  longint x_h      [3][N];
  longint c_h      [3][N][T];
  longint casc_h   [3][N];
  longint e_casc   [3];
  longint e_out    [3];
  bit     e_sat    [3];
  longint e_out_r;
  bit     e_sat_r;
  bit     e_valid;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  function automatic longint wrap24(longint v);
    return (v <<< 40) >>> 40;
  endfunction

  function automatic longint rnd2(longint v);
    return (v + 2) >>> 2;
  endfunction

  function automatic bit is_clamped(longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  function automatic longint clampv(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Last-stage value before strobe m: sample m-1-t weighted by the tap that
  // was active at its own strobe, plus the cascade input from TAPS strobes ago.
  function automatic longint conv(int i);
    longint s;
    int     m;
    int     idx;
    s = 0;
    m = n_m[i];
    for (int t = 0; t < T; t++) begin
      idx = m - 1 - t;
      if (idx >= 0) s += x_h[i][idx] * c_h[i][idx][T-1-t];
    end
    if (m - T >= 0) s += casc_h[i][m-T];
    return wrap24(s);
  endfunction

  task automatic model_update();
    longint ca_b, cin, raw;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        n_m[i] = 0; pend_m[i] = 0; e_casc[i] = 0; e_out[i] = 0; e_sat[i] = 0;
        for (int k = 0; k < T; k++) begin shadow_m[i][k] = 0; active_m[i][k] = 0; end
      end
      e_out_r = 0; e_sat_r = 0; e_valid = 0;
      return;
    end
    e_valid = en;
    if (en) begin
      ca_b = e_casc[1];
      for (int i = 0; i < 3; i++) begin
        cin = (i == 2) ? ca_b : longint'($signed(casc_in));
        raw = conv(i);
        x_h[i][n_m[i]] = longint'($signed(x));
        for (int k = 0; k < T; k++) c_h[i][n_m[i]][k] = active_m[i][k];
        casc_h[i][n_m[i]] = cin;
        n_m[i]++;
        e_casc[i] = raw;
        e_out[i]  = clampv(raw);
        if (is_clamped(raw)) e_sat[i] = 1; else if (satclr) e_sat[i] = 0;
      end
      e_out_r = clampv(rnd2(e_casc[0]));
      if (is_clamped(rnd2(e_casc[0]))) e_sat_r = 1; else if (satclr) e_sat_r = 0;
    end else if (satclr) begin
      for (int i = 0; i < 3; i++) e_sat[i] = 0;
      e_sat_r = 0;
    end
    for (int i = 0; i < 3; i++) begin
      if (pend_m[i] && en) begin
        for (int k = 0; k < T; k++) active_m[i][k] = shadow_m[i][k];
        pend_m[i] = 0;
      end else if (swap) begin
        pend_m[i] = 1;
      end
      if (we_v[i] && (addr < 4'(T))) shadow_m[i][addr] = longint'($signed(data));
    end
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("dut_valid", d_valid, e_valid);
    check("dut_casc", $signed(d_casc), e_casc[0]);
    check("dut_out", $signed(d_out), e_out[0]);
    check("dut_sat", d_sat, e_sat[0]);
    check("dut_pend", d_pend, pend_m[0]);
    check("rnd_valid", r_valid, e_valid);
    check("rnd_casc", $signed(r_casc), e_casc[0]);
    check("rnd_out", $signed(r_out), e_out_r);
    check("rnd_sat", r_sat, e_sat_r);
    check("rnd_pend", r_pend, pend_m[0]);
    check("a_valid", a_valid, e_valid);
    check("a_casc", $signed(a_casc), e_casc[1]);
    check("a_out", $signed(a_out), e_out[1]);
    check("a_sat", a_sat, e_sat[1]);
    check("a_pend", a_pend, pend_m[1]);
    check("b_valid", b_valid, e_valid);
    check("b_casc", $signed(b_casc), e_casc[2]);
    check("b_out", $signed(b_out), e_out[2]);
    check("b_sat", b_sat, e_sat[2]);
    check("b_pend", b_pend, pend_m[2]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic wr(input int inst, input int a, input int d);
    we_v = 3'(1 << inst);
    addr = a[3:0];
    data = d[15:0];
    cycle();
    we_v = '0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    cycle();
    swap = 1'b0;
  endtask

  task automatic strobe(input int xv, input bit clr);
    x = xv[2:0];
    en = 1'b1;
    satclr = clr;
    cycle();
    en = 1'b0;
    satclr = 1'b0;
    cycle();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; swap = 1'b0; satclr = 1'b0;
    x = '0; casc_in = '0; we_v = '0; addr = '0; data = '0;
    cycle();
    cycle();
    check("rst_out", $signed(d_out), 0);
    rst = 1'b0;

    // Impulse on main, cascade A (c=1..10) and B (c=11..20).
    for (int k = 0; k < T; k++) begin
      wr(0, k, k + 1);
      wr(1, k, k + 1);
      wr(2, k, k + 11);
    end
    do_swap();
    check("swap_req", d_pend, 1);
    strobe(0, 0);
    check("swap_done", d_pend, 0);
    strobe(1, 0);
    for (int j = 0; j <= 10; j++) begin
      strobe(0, 0);
      check("impulse", $signed(d_out), (j < 10) ? 10 - j : 0);
    end
    for (int j = 0; j < 12; j++) strobe(0, 0);

    // Writes beyond the last tap are dropped.
    wr(0, 12, 500);
    wr(0, 15, 500);

    // Swap timing: all 1s active, shadow all 2s, swap requested with a strobe.
    for (int k = 0; k < T; k++) wr(0, k, 1);
    do_swap();
    strobe(0, 0);
    for (int j = 0; j < 12; j++) strobe(1, 0);
    check("pre_swap", $signed(d_out), 10);
    for (int k = 0; k < T; k++) wr(0, k, 2);
    x = 3'd1; en = 1'b1; swap = 1'b1;
    cycle();
    en = 1'b0; swap = 1'b0;
    cycle();
    check("swap_strobe_pend", d_pend, 1);
    check("swap_strobe_out", $signed(d_out), 10);
    do_swap();
    for (int j = 1; j <= 12; j++) begin
      strobe(1, 0);
      if (j == 1) check("swap_applied", d_pend, 0);
      check("swap_step", $signed(d_out), (j < 3) ? 10 : 8 + j);
    end

    // Saturation on both rails; a clear during a clamp leaves the flag set.
    for (int k = 0; k < T; k++) wr(0, k, 32767);
    do_swap();
    strobe(0, 0);
    for (int j = 0; j < 12; j++) strobe(3, 0);
    check("sat_hi", $signed(d_out), 32767);
    check("sat_flag", d_sat, 1);
    for (int j = 0; j < 11; j++) strobe(-4, 0);
    check("sat_lo", $signed(d_out), -32768);
    strobe(-4, 1);
    check("sat_set_wins", d_sat, 1);
    for (int j = 0; j < 12; j++) strobe(0, 0);
    check("sat_drain", $signed(d_out), 0);
    satclr = 1'b1;
    cycle();
    satclr = 1'b0;
    check("sat_clr", d_sat, 0);

    // Rounding with OUT_SHIFT=2: sums 6, 5 and -6.
    for (int k = 0; k < T; k++) wr(0, k, (k == 9) ? 6 : ((k == 8) ? 5 : 0));
    do_swap();
    strobe(0, 0);
    strobe(1, 0);
    strobe(0, 0);
    check("rnd_6", $signed(r_out), 2);
    strobe(0, 0);
    check("rnd_5", $signed(r_out), 1);
    for (int j = 0; j < 10; j++) strobe(0, 0);
    strobe(-1, 0);
    strobe(0, 0);
    check("rnd_m6", $signed(r_out), -1);
    for (int j = 0; j < 10; j++) strobe(0, 0);

    // Reset mid-stream with a swap pending.
    for (int k = 0; k < T; k++) wr(0, k, 100 + k);
    do_swap();
    strobe(0, 0);
    strobe(3, 0);
    strobe(2, 0);
    do_swap();
    x = 3'd2; en = 1'b1; rst = 1'b1;
    cycle();
    rst = 1'b0; en = 1'b0;
    check("rst_pend", d_pend, 0);
    check("rst_casc", $signed(d_casc), 0);
    check("rst_valid", d_valid, 0);
    do_swap();
    strobe(0, 0);
    strobe(1, 0);
    for (int j = 0; j < 11; j++) begin
      strobe(0, 0);
      check("post_rst_imp", $signed(d_out), 0);
    end

    // Randomized traffic on every input.
    for (int c = 0; c < 500; c++) begin
      en      = 1'($urandom_range(0, 1));
      x       = 3'($urandom);
      casc_in = 24'($urandom);
      we_v    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
      addr    = 4'($urandom);
      data    = 16'($urandom);
      swap    = ($urandom_range(0, 7) == 0);
      satclr  = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; en = 1'b0; swap = 1'b0; satclr = 1'b0; we_v = '0;
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
